// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front-end with DEPTH-entry FIFO and redirect flush
//
// Fetches words from a 1-cycle-latency synchronous instruction memory and queues
// {pc, word} pairs for decode behind a valid/ready handshake. A redirect from
// execute flushes the queue, drops the in-flight read and reloads the PC.
//
// Optional build macro: FETCH_QUEUE_BYPASS_EN presents a returning word directly
// to decode when the queue is empty (1-cycle fetch-to-decode latency).
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   imem_req, imem_addr          read strobe and word address (combinational)
//   imem_rdata                   read data, valid the cycle after imem_req
//   redirect, redirect_pc        1-cycle flush pulse and new PC
//   instr_valid, instr, instr_pc queue head presented to decode
//   instr_ready                  decode accepts the head this cycle
//   count                        occupied queue entries
module fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              AW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [AW-1:0]              imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [AW-1:0]              redirect_pc,
    output logic                       instr_valid,
    output logic [31:0]                instr,
    output logic [AW-1:0]              instr_pc,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t          state;
    logic [AW-1:0]   pc;
    logic [AW-1:0]   req_pc;
    logic            inflight;
    logic            kill;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic [31:0]     fifo_data [DEPTH];
    logic [AW-1:0]   fifo_pc   [DEPTH];

    logic            ret;
    logic            fifo_empty;
    logic [CW:0]     used;
    logic            push;
    logic            pop_fifo;

    // A word returning in the redirect cycle belongs to the old stream.
    assign ret        = inflight & ~kill & ~redirect;
    assign fifo_empty = (count_q == '0);

    // Credit check counts the in-flight read so the FIFO can never overflow.
    assign used      = {1'b0, count_q} + (CW+1)'(inflight);
    assign imem_req  = (state == RUN) & (used < (CW+1)'(DEPTH)) & ~redirect;
    assign imem_addr = pc;
    assign count     = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic byp;
    assign byp         = fifo_empty & ret;
    assign instr_valid = (~fifo_empty | byp) & ~redirect;
    assign instr       = byp ? imem_rdata : fifo_data[rd_ptr];
    assign instr_pc    = byp ? req_pc     : fifo_pc[rd_ptr];
    // A bypassed word taken by decode this cycle never enters the FIFO.
    assign push        = ret & ~(byp & instr_ready);
`else
    assign instr_valid = ~fifo_empty & ~redirect;
    assign instr       = fifo_data[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];
    assign push        = ret;
`endif

    assign pop_fifo = ~fifo_empty & instr_valid & instr_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc     <= pc + {{(AW-1){1'b0}}, 1'b1};
                req_pc <= pc;
            end
            if (redirect) begin
                state   <= FLUSH;
                pc      <= redirect_pc;
                kill    <= inflight;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count_q <= '0;
            end else begin
                kill  <= 1'b0;
                state <= RUN;
                if (push) begin
                    fifo_data[wr_ptr] <= imem_rdata;
                    fifo_pc[wr_ptr]   <= req_pc;
                    wr_ptr            <= wr_ptr + PW'(1);
                end
                if (pop_fifo)
                    rd_ptr <= rd_ptr + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop_fifo);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a queue-based model
module tb_fetch_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    fetch_queue #(.DEPTH(4), .AW(32), .RESET_PC(32'h0)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .count       (count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a + 32'h100;
    endfunction

    // Synchronous instruction memory, one cycle of read latency.
    always @(posedge clock)
        if (imem_req) imem_rdata <= mem_word(imem_addr);

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: delivered words as a queue, fetch side as next-pc plus
    // one outstanding read, and a count of idle cycles before fetching resumes.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_inflight;
    bit          m_kill;
    int          m_wait;

    function automatic bit m_byp();
`ifdef FETCH_QUEUE_BYPASS_EN
        return (mq.size() == 0) && m_inflight && !m_kill;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_valid();
        return ((mq.size() != 0) || m_byp()) && !redirect;
    endfunction

    function automatic bit m_req();
        return (m_wait == 0) && ((mq.size() + int'(m_inflight)) < 4) && !redirect;
    endfunction

    always @(posedge clock or posedge reset) begin : model
        bit ret, pop, issue;
        if (reset) begin
            mq.delete();
            m_pc       = 32'h0;
            m_req_pc   = 32'h0;
            m_inflight = 0;
            m_kill     = 0;
            m_wait     = 1;
        end else begin
            ret   = m_inflight && !m_kill && !redirect;
            pop   = m_valid() && instr_ready;
            issue = m_req();
            if (redirect) begin
                mq.delete();
                m_pc       = redirect_pc;
                m_kill     = m_inflight;
                m_inflight = 0;
                m_wait     = 1;
            end else begin
                if (pop) begin
                    if (mq.size() != 0) void'(mq.pop_front());
                    else ret = 0;
                end
                if (ret) mq.push_back('{m_req_pc, mem_word(m_req_pc)});
                m_kill = 0;
                if (m_wait > 0) m_wait--;
                m_inflight = issue;
                if (issue) begin
                    m_req_pc = m_pc;
                    m_pc     = m_pc + 32'h1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started && !reset) begin
            check("req", 64'(imem_req), 64'(m_req()));
            check("addr", 64'(imem_addr), 64'(m_pc));
            check("valid", 64'(instr_valid), 64'(m_valid()));
            check("count", 64'(count), 64'(mq.size()));
            if (m_valid()) begin
                if (mq.size() != 0) begin
                    check("instr", 64'(instr), 64'(mq[0].w));
                    check("instr_pc", 64'(instr_pc), 64'(mq[0].pc));
                end else begin
                    check("instr_byp", 64'(instr), 64'(mem_word(m_req_pc)));
                    check("instr_pc_byp", 64'(instr_pc), 64'(m_req_pc));
                end
            end
        end
    end

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        @(posedge clock);
        #3;
        redirect = 1'b0;
        reset    = 1'b1;
        #1;
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_pc", 64'(instr_pc), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        @(posedge clock);
        #3;
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int  first;
        int  nval;
        bit  found;
        logic [31:0] got_pc;
        logic [31:0] got_w;

        #1 reset = 1'b1;
        started = 1;

        // Directed 1: straight-line fetch from RESET_PC.
        do_reset();
        instr_ready = 1'b1;
        first = -1;
        nval  = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            if (k == 1) check("t1_addr0", 64'(imem_addr), 64'h0);
            if (instr_valid) begin
                if (first < 0) first = k;
                if (nval < 6) begin
                    check("t1_instr", 64'(instr), 64'(32'h100 + nval));
                    check("t1_pc", 64'(instr_pc), 64'(nval));
                end
                nval++;
            end
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        check("t1_first_valid", 64'(first), 64'd2);
`else
        check("t1_first_valid", 64'(first), 64'd3);
`endif

        // Directed 2: stall fills exactly DEPTH entries, then drain with no gap.
        do_reset();
        instr_ready = 1'b0;
        repeat (10) @(negedge clock);
        check("t2_count", 64'(count), 64'd4);
        check("t2_req", 64'(imem_req), 64'd0);
        step();
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("t2_valid", 64'(instr_valid), 64'd1);
            check("t2_instr", 64'(instr), 64'(32'h100 + i));
        end

        // Directed 3: redirect with count=3 and a read in flight.
        do_reset();
        instr_ready = 1'b0;
        repeat (5) @(negedge clock);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clock);
        check("t3_count_pre", 64'(count), 64'd3);
        step();
        redirect = 1'b0;
        @(negedge clock);
        check("t3_count_flush", 64'(count), 64'd0);
        check("t3_req_flush", 64'(imem_req), 64'd0);
        @(negedge clock);
        check("t3_req", 64'(imem_req), 64'd1);
        check("t3_addr", 64'(imem_addr), 64'h40);
        instr_ready = 1'b1;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clock);
            if (instr_valid) begin
                found  = 1;
                got_pc = instr_pc;
                got_w  = instr;
            end
        end
        check("t3_found", 64'(found), 64'd1);
        check("t3_first_pc", 64'(got_pc), 64'h40);
        check("t3_first_instr", 64'(got_w), 64'h140);

        // Directed 4: back-to-back redirects, only the second target survives.
        do_reset();
        instr_ready = 1'b1;
        repeat (4) @(negedge clock);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clock);
            if (instr_valid) begin
                found  = 1;
                got_pc = instr_pc;
                got_w  = instr;
            end
        end
        check("t4_found", 64'(found), 64'd1);
        check("t4_first_pc", 64'(got_pc), 64'h80);
        check("t4_first_instr", 64'(got_w), 64'h180);

        // Random traffic with occasional redirects (some near the PC wrap) and resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step();
                instr_ready = ($urandom_range(0, 3) != 0);
                redirect    = ($urandom_range(0, 11) == 0);
                case ($urandom_range(0, 2))
                    0: redirect_pc = $urandom;
                    1: redirect_pc = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                    default: redirect_pc = 32'($urandom_range(0, 255));
                endcase
            end
        end
        step();
        redirect = 1'b0;
        repeat (3) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
